apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB4 requester: turns single-beat commands from a local valid/ready port into
//  IDLE/SETUP/ACCESS transfers towards one APB completer (e.g. our 32-word APB
//  slave). Returns read data, error and timeout status on a one-cycle response
//  pulse. Sits between the test/CPU-side command source and the APB bus.
// PARAMETERS
//  ADDR_W   5   paddr / cmd_addr width (32-word completer space)
//  DATA_W   32  data width; strobe width = DATA_W/8
//  TIMEOUT  16  max wait-state cycles in ACCESS before abort; 0 = never abort
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  resetn       in   1         reset, asynchronous, active-low
//  cmd_valid    in   1         command request
//  cmd_ready    out  1         high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_write    in   1         1 = write, 0 = read
//  cmd_addr     in   ADDR_W    target address
//  cmd_wdata    in   DATA_W    write data
//  cmd_strb     in   DATA_W/8  byte-lane write strobes
//  cmd_prot     in   3         protection attribute, passed to pprot
//  rsp_valid    out  1         one-cycle completion pulse
//  rsp_rdata    out  DATA_W    read data (0 for writes and timeouts)
//  rsp_err      out  1         pslverr at completion, or timeout
//  rsp_timeout  out  1         transfer aborted by wait-state limit
//  psel         out  1         APB select
//  penable      out  1         APB enable (ACCESS phase)
//  pwrite       out  1         APB direction
//  paddr        out  ADDR_W    APB address
//  pwdata       out  DATA_W    APB write data
//  pstrb        out  DATA_W/8  APB strobes
//  pprot        out  3         APB protection
//  pready       in   1         completer ready / wait-state control
//  prdata       in   DATA_W    completer read data
//  pslverr      in   1         completer error, valid only with pready in ACCESS
// BEHAVIOUR
//  - Reset (resetn low, async): state IDLE, every APB and rsp_* output 0, wait
//    counter 0, cmd_ready 0 while resetn low. Reset mid-transfer aborts it; no
//    rsp_valid is produced for the aborted command.
//  - All outputs except cmd_ready are registered; cmd_ready = (state==IDLE).
//  - IDLE: on accept at edge E0 capture cmd_*, go SETUP: psel=1, penable=0,
//    paddr/pwrite/pprot driven. Writes: pwdata=cmd_wdata, pstrb=cmd_strb.
//    Reads: pwdata=0, pstrb=0 regardless of cmd_strb.
//  - SETUP -> ACCESS unconditionally at E1: penable=1, counter cleared.
//  - ACCESS, edge with pready=1: psel=penable=0, go IDLE, rsp_valid=1 for the
//    following cycle; rsp_rdata = read ? prdata : 0; rsp_err = pslverr;
//    rsp_timeout = 0.
//  - ACCESS, pready=0: stay, hold paddr/pwrite/pwdata/pstrb/pprot stable,
//    counter +1 (saturating, width clog2(TIMEOUT+1)).
//  - Timeout: TIMEOUT!=0 and counter==TIMEOUT with pready still 0 at an edge:
//    drop psel/penable, go IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rdata=0.
//    pready=1 at that same edge wins: normal completion, no timeout.
//  - Zero wait states: accept E0, response visible after E2; 3 cycles/transfer
//    minimum. No back-to-back SETUP; a new command is accepted only in IDLE, so
//    psel always returns low for >=1 cycle between transfers.
//  - cmd_valid while cmd_ready=0 is ignored (not queued); source must hold.
//  - pslverr and prdata are ignored outside ACCESS&pready.
//  - rsp_* other than rsp_valid hold their last value until the next response.
// TESTING
//  - Write addr 5, data 0xDEADBEEF, strb 0xF, pready tied 1 -> psel 2 cycles,
//    penable 1 cycle, rsp_valid 2 edges after accept, rsp_err=0, rdata=0.
//  - Read addr 5 with pready low 2 ACCESS cycles, prdata=0xDEADBEEF -> paddr
//    stable 4 cycles, pstrb=0, rsp_rdata=0xDEADBEEF exactly one pulse.
//  - Write with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
//  - TIMEOUT=16, pready never 1 -> abort after 16 wait cycles, rsp_err=1,
//    rsp_timeout=1, psel low next cycle; pready=1 on edge 16 -> normal finish.
//  - cmd_valid held high across 3 commands -> one accept per IDLE, psel low >=1
//    cycle between transfers, responses in order.
//  - resetn low during ACCESS -> all outputs 0 asynchronously, no rsp_valid;
//    after release, next command completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB4 requester. Accepts single-beat commands on a local valid/ready port and
// runs each one as an IDLE -> SETUP -> ACCESS transfer towards one APB
// completer. Completion (normal, slave error or wait-state timeout) is reported
// on a one-cycle rsp_valid pulse together with read data and status.
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the bridge is idle and
// out of reset. cmd_valid seen while cmd_ready is low is ignored, not queued;
// the source holds its command until accepted. There is no back-pressure on
// the response side: rsp_valid is a pulse the consumer must take.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/addr/wdata/strb/prot   command payload, captured on accept
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout    completion status, held until next response
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   APB requester outputs
//   pready/prdata/pslverr       APB completer inputs
//   dbg_state                   current transfer state (IDLE/SETUP/ACCESS)
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [2:0]            cmd_prot,
    // response port
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pslverr,
    // debug
    output logic [1:0]            dbg_state
);

    localparam int STRB_W = DATA_W / 8;

    // Counter must hold the value TIMEOUT; keep at least one bit so the
    // TIMEOUT = 0 (never abort) build still has a legal vector.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               TO_EN     = (TIMEOUT != 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    logic accept;
    logic in_access;
    logic access_done;
    logic access_abort;

    // Held at 0 during reset so a source never sees an accept it cannot get.
    assign cmd_ready = resetn & (state == ST_IDLE);
    assign dbg_state = state;

    assign accept      = cmd_valid & cmd_ready;
    assign in_access   = (state == ST_ACCESS);
    assign access_done = in_access & pready;
    // pready at the limit edge wins: the abort only fires when pready is low.
    assign access_abort = in_access & ~pready & TO_EN & (wait_cnt == CNT_LIMIT);

    // ------------------------------------------------------------------
    // Transfer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done || access_abort) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wait-state counter: cleared on entry to ACCESS, counts edges where
    // the completer stalls, saturates rather than wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (in_access && !pready && !access_abort) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // APB control: psel rises on accept, penable rises entering ACCESS,
    // both drop together when the transfer ends either way.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            if (accept) begin
                psel    <= 1'b1;
                penable <= 1'b0;
            end else if (state == ST_SETUP) begin
                penable <= 1'b1;
            end else if (access_done || access_abort) begin
                psel    <= 1'b0;
                penable <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // APB payload: loaded only on accept, so it stays stable through SETUP
    // and every ACCESS wait state. Reads never present write lanes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
            pprot  <= 3'b000;
        end else if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pprot  <= cmd_prot;
            if (cmd_write) begin
                pwdata <= cmd_wdata;
                pstrb  <= cmd_strb;
            end else begin
                pwdata <= '0;
                pstrb  <= {STRB_W{1'b0}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Response: rsp_valid is a single-cycle pulse; the status fields keep
    // their last value until the next completion overwrites them.
    // prdata/pslverr are sampled only on the completing ACCESS edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (access_done) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (access_abort) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Transaction-level model: each command is expanded into a per-cycle timeline
// (gap, accept, setup, N access cycles) with the inputs to drive and the
// outputs expected in that cycle. N follows from the completer's wait count
// and the timeout limit. One engine process compares every cycle on the
// falling edge and then drives the next inputs.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 16;

  // clock/reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [2:0]        pprot;
  logic              pready, pslverr;
  logic [DATA_W-1:0] prdata;
  logic [1:0]        dbg_state;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // one cycle of the timeline: inputs driven in this cycle, outputs expected
  typedef struct {
    logic              cv, cw;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    logic [STRB_W-1:0] cs;
    logic [2:0]        cp;
    logic              pr, pse;
    logic [DATA_W-1:0] prd;
    logic              e_ready, e_psel, e_pen, e_pw;
    logic [ADDR_W-1:0] e_pa;
    logic [DATA_W-1:0] e_pwd;
    logic [STRB_W-1:0] e_ps;
    logic [2:0]        e_pp;
    logic              e_rv, e_re, e_rt;
    logic [DATA_W-1:0] e_rd;
  } cyc_t;

  cyc_t sched[$];

  // model state
  logic              m_pw;
  logic [ADDR_W-1:0] m_pa;
  logic [DATA_W-1:0] m_pwd;
  logic [STRB_W-1:0] m_ps;
  logic [2:0]        m_pp;
  logic              m_rv_pending, m_re, m_rt;
  logic [DATA_W-1:0] m_rd;

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;
  int psel_cnt, pen_cnt, rv_cnt, b2b_cnt;
  logic prev_access;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pw = 0; m_pa = '0; m_pwd = '0; m_ps = '0; m_pp = '0;
    m_rv_pending = 0; m_re = 0; m_rt = 0; m_rd = '0;
  endtask

  task automatic clear_counters();
    psel_cnt = 0; pen_cnt = 0; rv_cnt = 0; b2b_cnt = 0; prev_access = 0;
  endtask

  // build one cycle record with random (don't-care) inputs and the model's
  // current expectations
  task automatic mk_rec(output cyc_t c, input logic cv, input logic rdy, input logic sel, input logic en);
    c.cv = cv; c.cw = 1'($urandom); c.ca = ADDR_W'($urandom); c.cd = $urandom;
    c.cs = STRB_W'($urandom); c.cp = 3'($urandom);
    c.pr = 1'($urandom); c.pse = 1'($urandom); c.prd = $urandom;
    c.e_ready = rdy; c.e_psel = sel; c.e_pen = en;
    c.e_pw = m_pw; c.e_pa = m_pa; c.e_pwd = m_pwd; c.e_ps = m_ps; c.e_pp = m_pp;
    c.e_rv = m_rv_pending; c.e_rd = m_rd; c.e_re = m_re; c.e_rt = m_rt;
    m_rv_pending = 0;
  endtask

  task automatic add_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      mk_rec(c, 1'b0, 1'b1, 1'b0, 1'b0);
      sched.push_back(c);
    end
  endtask

  // waits = ACCESS cycles the completer holds pready low before raising it
  task automatic add_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [STRB_W-1:0] s, input logic [2:0] p, input int waits,
                         input logic slverr, input logic [DATA_W-1:0] rdata, input int gap,
                         input logic hold);
    cyc_t c;
    logic tmo;
    int   n_acc;
    add_idle(gap);
    mk_rec(c, 1'b1, 1'b1, 1'b0, 1'b0);
    c.cw = w; c.ca = a; c.cd = d; c.cs = s; c.cp = p;
    sched.push_back(c);
    m_pw = w; m_pa = a; m_pp = p;
    m_pwd = w ? d : '0;
    m_ps  = w ? s : '0;
    tmo   = (TIMEOUT != 0) && (waits > TIMEOUT);
    n_acc = tmo ? TIMEOUT + 1 : waits + 1;
    // setup: pready/prdata/pslverr are random and must be ignored
    mk_rec(c, hold ? 1'b1 : 1'($urandom), 1'b0, 1'b1, 1'b0);
    sched.push_back(c);
    for (int i = 0; i < n_acc; i++) begin
      mk_rec(c, hold ? 1'b1 : 1'($urandom), 1'b0, 1'b1, 1'b1);
      if (!tmo && i == waits) begin
        c.pr = 1'b1; c.prd = rdata; c.pse = slverr;
      end else begin
        c.pr = 1'b0;
      end
      sched.push_back(c);
    end
    m_rv_pending = 1;
    m_rd = (tmo || w) ? '0 : rdata;
    m_re = tmo ? 1'b1 : slverr;
    m_rt = tmo;
  endtask

  task automatic drive_idle();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    pready = 0; prdata = '0; pslverr = 0;
  endtask

  task automatic compare(input cyc_t c);
    chk("cmd_ready", cmd_ready, c.e_ready);
    chk("psel", psel, c.e_psel);
    chk("penable", penable, c.e_pen);
    chk("rsp_valid", rsp_valid, c.e_rv);
    chk("rsp_rdata", rsp_rdata, c.e_rd);
    chk("rsp_err", rsp_err, c.e_re);
    chk("rsp_timeout", rsp_timeout, c.e_rt);
    if (c.e_psel) begin
      chk("pwrite", pwrite, c.e_pw);
      chk("paddr", paddr, c.e_pa);
      chk("pwdata", pwdata, c.e_pwd);
      chk("pstrb", pstrb, c.e_ps);
      chk("pprot", pprot, c.e_pp);
    end
    if (psel) psel_cnt++;
    if (penable) pen_cnt++;
    if (rsp_valid) rv_cnt++;
    if (prev_access && psel && !penable) b2b_cnt++;
    prev_access = psel & penable;
  endtask

  // compare process: check outputs of this cycle, then drive its inputs
  task automatic run_sched(input int max_n);
    cyc_t c;
    int   n = 0;
    while (sched.size() > 0 && n < max_n) begin
      c = sched.pop_front();
      @(negedge clk);
      compare(c);
      cmd_valid = c.cv; cmd_write = c.cw; cmd_addr = c.ca; cmd_wdata = c.cd;
      cmd_strb = c.cs; cmd_prot = c.cp;
      pready = c.pr; prdata = c.prd; pslverr = c.pse;
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_pstrb"}, pstrb, 0);
    chk({tag, "_pprot"}, pprot, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, sel;
    drive_idle();
    model_reset();
    clear_counters();
    resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk("reset_state", dbg_state, 0);
    resetn = 1;

    // write, zero wait states
    clear_counters();
    add_cmd(1, 5'd5, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 32'h0, 1, 0);
    add_idle(2);
    run_sched(1000);
    chk("wr_psel_cycles", psel_cnt, 2);
    chk("wr_penable_cycles", pen_cnt, 1);
    chk("wr_rsp_pulses", rv_cnt, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);

    // read, two wait states; strobes presented must be ignored
    clear_counters();
    add_cmd(0, 5'd5, 32'h11111111, 4'hF, 3'd2, 2, 0, 32'hDEADBEEF, 1, 0);
    add_idle(2);
    run_sched(1000);
    chk("rd_psel_cycles", psel_cnt, 4);
    chk("rd_rsp_pulses", rv_cnt, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    // write with slave error
    clear_counters();
    add_cmd(1, 5'd9, 32'hA5A5A5A5, 4'h3, 3'd1, 1, 1, 32'h0, 0, 0);
    add_idle(2);
    run_sched(1000);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_timeout", rsp_timeout, 0);

    // completer never ready: abort after TIMEOUT wait cycles
    clear_counters();
    add_cmd(0, 5'd3, 32'h0, 4'h0, 3'd0, 40, 0, 32'hCAFEF00D, 1, 0);
    add_idle(2);
    run_sched(1000);
    chk("to_psel_cycles", psel_cnt, 18);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);

    // pready arrives on the limit edge: normal completion wins
    clear_counters();
    add_cmd(0, 5'd4, 32'h0, 4'h0, 3'd0, TIMEOUT, 0, 32'h12345678, 1, 0);
    add_idle(2);
    run_sched(1000);
    chk("lim_psel_cycles", psel_cnt, 18);
    chk("lim_rsp_timeout", rsp_timeout, 0);
    chk("lim_rsp_rdata", rsp_rdata, 32'h12345678);

    // cmd_valid held across three commands
    clear_counters();
    add_cmd(1, 5'd1, 32'h00000001, 4'h1, 3'd0, 0, 0, 32'h0, 0, 1);
    add_cmd(0, 5'd2, 32'h0, 4'hF, 3'd0, 1, 0, 32'h22222222, 0, 1);
    add_cmd(1, 5'd3, 32'h00000003, 4'h8, 3'd7, 0, 0, 32'h0, 0, 1);
    add_idle(2);
    run_sched(1000);
    chk("hold_rsp_pulses", rv_cnt, 3);
    chk("hold_back_to_back", b2b_cnt, 0);

    // reset in the middle of an ACCESS phase
    clear_counters();
    add_cmd(0, 5'd7, 32'h0, 4'h0, 3'd0, 10, 0, 32'h77777777, 1, 0);
    run_sched(5);
    #2 resetn = 0;
    #1 check_all_zero("midreset");
    drive_idle();
    sched.delete();
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    add_idle(3);
    add_cmd(0, 5'd6, 32'h0, 4'h0, 3'd0, 0, 0, 32'h66666666, 0, 0);
    add_idle(2);
    run_sched(1000);
    chk("post_reset_rsp_pulses", rv_cnt, 1);
    chk("post_reset_rdata", rsp_rdata, 32'h66666666);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      waits = $urandom_range(0, 3);
      else if (sel <= 7) waits = $urandom_range(4, 6);
      else if (sel == 8) waits = $urandom_range(TIMEOUT, TIMEOUT + 1);
      else               waits = 30;
      add_cmd(1'($urandom), ADDR_W'($urandom), $urandom, STRB_W'($urandom), 3'($urandom),
              waits, 1'($urandom), $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    add_idle(2);
    run_sched(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
